pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle MIPS CPU; sits directly upstream of the Control decoder.
- Owns the PC register and selects the next PC from the 3-bit PCSrc code that Control returns.
- Drives the instruction ROM address and forwards the fetched word to Control and the datapath.
- Latches timer interrupts and presents a gated IRQ to Control; PC[31] is the kernel/supervise bit.

Parameters:
- RESET_VEC, 32'h8000_0000, PC value after reset.
- IRQ_VEC, 32'h8000_0004, interrupt handler entry.
- XADR_VEC, 32'h8000_0008, illegal-instruction handler entry.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC this cycle (memory wait)
- pc_src  in  3  next-PC select from Control
- branch_taken  in  1  ALUOut[0] from the datapath
- reg_target  in  32  rs value for JR/JALR
- irq_raw  in  1  level interrupt from timer peripheral
- instr_rdata  in  32  instruction ROM read data
- instr_addr  out  32  ROM address = pc
- instruction  out  32  = instr_rdata, to Control and datapath
- pc  out  32  current PC register
- link_addr  out  32  value Control writes to $ra/$k0
- irq  out  1  gated interrupt request to Control
- supervise  out  1  = pc[31]

Behaviour:
- Reset (synchronous): pc=RESET_VEC; irq_pending=0; irq_prev=0; supervise=1; irq=0.
- pc_plus4 = {pc[31], pc[30:0]+31'd4}; the carry never alters bit 31.
- next PC by pc_src:
  - 000: pc_plus4
  - 001: if branch_taken, {pc[31], pc_plus4[30:0] + (sext(instruction[15:0])<<2)} (31-bit wrap); otherwise pc_plus4
  - 010: {pc_plus4[31:28], instruction[25:0], 2'b00}
  - 011: reg_target; when pc[31]=0, bit 31 is forced to 0 (user code cannot enter kernel). Kernel JR may clear it (exception return).
  - 100: IRQ_VEC
  - 101: XADR_VEC
  - 110/111: pc_plus4 (reserved)
- pc updates on each rising edge when stall=0. With stall=1, pc holds and no pending clear occurs.
- link_addr: pc when pc_src=100 (interrupted instruction is re-executed on return); otherwise pc_plus4.
- IRQ latch:
  - irq_prev <= irq_raw every cycle.
  - A rising edge (irq_raw & ~irq_prev) sets irq_pending.
  - irq_pending clears on a non-stalled cycle with irq=1 and pc_src=100.
  - Set and clear in the same cycle: pending stays 1.
  - irq = irq_pending & ~pc[31], so interrupts are deferred while in kernel mode and taken on the first user-mode cycle after return.
  - A level held high produces exactly one pending event.
- instruction is combinational from instr_rdata; there is no extra fetch latency.
- Reset mid-stall or with irq pending: reset wins and all state returns to reset values.

Optional Feature:
- PC_FETCH_INSTR_CNT_EN
- Defined:
  - adds output instr_cnt[31:0]
  - reset 0; increments on every non-stalled cycle, wraps at 2^32
  - frozen while stall=1
- Undefined: port and counter are absent.

Decomposition:
- mips_pkg holds:
  - PCSRC_SEQ/BRANCH/JUMP/JR/IRQ/XADR localparam codes, shared with Control
  - RESET_VEC/IRQ_VEC/XADR_VEC defaults
- One sub-module, irq_pending_latch: edge detect, set/clear priority, kernel gating. Ports: clk, reset, irq_raw, take, supervise, irq.

Test Plan:
- reset=1 for 2 cycles, then pc_src=000 for 3 cycles -> pc 80000000, 80000004, 80000008, 8000000C; supervise=1.
- pc=00000010, pc_src=001, branch_taken=1, instruction[15:0]=FFFF -> next pc=00000010. Same with branch_taken=0 -> 00000014.
- pc=00000020, pc_src=010, instruction[25:0]=0000040 -> pc=00000100, link_addr=00000024.
- pc=00000040 (user), pc_src=011, reg_target=80001000 -> pc=00001000 (bit 31 masked). In kernel, reg_target=00000200 -> pc=00000200, supervise=0.
- irq_raw pulses while pc=80000010 -> irq=0 until JR to 00000300. Then irq=1; pc_src=100 -> pc=80000004, link_addr=00000300, pending cleared.
- stall=1 for 3 cycles at pc=00000050 with pc_src=000 -> pc stays 00000050, instr_cnt frozen (when PC_FETCH_INSTR_CNT_EN defined).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: next-PC select codes (also used by Control) and the
// default reset/interrupt/illegal-instruction vectors.
package mips_pkg;

  localparam logic [2:0] PCSRC_SEQ    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_JR     = 3'b011;
  localparam logic [2:0] PCSRC_IRQ    = 3'b100;
  localparam logic [2:0] PCSRC_XADR   = 3'b101;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

  // Sequential successor; the kernel bit is never touched by the carry.
  function automatic logic [31:0] pc_plus4_f(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage signal bundle between Control/datapath/ROM (master) and the
// fetch unit (slave). PC_FETCH_INSTR_CNT_EN adds the retired-cycle counter.
interface pc_fetch_unit_if;

  logic        stall;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [31:0] reg_target;
  logic        irq_raw;
  logic [31:0] instr_rdata;
  logic [31:0] instr_addr;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        irq;
  logic        supervise;
`ifdef PC_FETCH_INSTR_CNT_EN
  logic [31:0] instr_cnt;

  modport master (
    output stall, pc_src, branch_taken, reg_target, irq_raw, instr_rdata,
    input  instr_addr, instruction, pc, link_addr, irq, supervise, instr_cnt
  );

  modport slave (
    input  stall, pc_src, branch_taken, reg_target, irq_raw, instr_rdata,
    output instr_addr, instruction, pc, link_addr, irq, supervise, instr_cnt
  );
`else
  modport master (
    output stall, pc_src, branch_taken, reg_target, irq_raw, instr_rdata,
    input  instr_addr, instruction, pc, link_addr, irq, supervise
  );

  modport slave (
    input  stall, pc_src, branch_taken, reg_target, irq_raw, instr_rdata,
    output instr_addr, instruction, pc, link_addr, irq, supervise
  );
`endif

endinterface

// File: rtl/pc_fetch_unit_irq_pending_latch.sv
// Timer interrupt latch: rising-edge capture, hold until taken, and masking
// while the CPU runs in kernel (supervise) mode.
module irq_pending_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_raw,
  input  logic take,
  input  logic supervise,
  output logic irq
);

  logic irq_prev;
  logic irq_pending;
  logic irq_rise;

  assign irq_rise = irq_raw & ~irq_prev;

  // A new edge arriving in the same cycle as the take keeps the request alive.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev    <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_prev    <= irq_raw;
      irq_pending <= irq_rise | (irq_pending & ~take);
    end
  end

  assign irq = irq_pending & ~supervise;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and interrupt latch.
// Optional macro PC_FETCH_INSTR_CNT_EN adds the instr_cnt output.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_unit_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [30:0] branch_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] next_pc;
  logic        irq_w;
  logic        take;

  assign pc_plus4   = pc_plus4_f(pc_q);
  assign branch_off = {{13{bus.instr_rdata[15]}}, bus.instr_rdata[15:0], 2'b00};
  assign branch_tgt = {pc_q[31], pc_plus4[30:0] + branch_off};
  assign jump_tgt   = {pc_plus4[31:28], bus.instr_rdata[25:0], 2'b00};
  // User code may only jump within user space; kernel JR may drop to user.
  assign jr_tgt     = {bus.reg_target[31] & pc_q[31], bus.reg_target[30:0]};

  always_comb begin
    next_pc = pc_plus4;
    case (bus.pc_src)
      PCSRC_SEQ:    next_pc = pc_plus4;
      PCSRC_BRANCH: next_pc = bus.branch_taken ? branch_tgt : pc_plus4;
      PCSRC_JUMP:   next_pc = jump_tgt;
      PCSRC_JR:     next_pc = jr_tgt;
      PCSRC_IRQ:    next_pc = IRQ_VEC;
      PCSRC_XADR:   next_pc = XADR_VEC;
      default:      next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
    end else if (!bus.stall) begin
      pc_q <= next_pc;
    end
  end

  assign take = ~bus.stall & irq_w & (bus.pc_src == PCSRC_IRQ);

  irq_pending_latch u_irq (
    .clk       (clk),
    .reset     (reset),
    .irq_raw   (bus.irq_raw),
    .take      (take),
    .supervise (pc_q[31]),
    .irq       (irq_w)
  );

  // On interrupt entry the interrupted instruction is replayed, so link to it.
  assign bus.link_addr   = (bus.pc_src == PCSRC_IRQ) ? pc_q : pc_plus4;
  assign bus.pc          = pc_q;
  assign bus.instr_addr  = pc_q;
  assign bus.instruction = bus.instr_rdata;
  assign bus.irq         = irq_w;
  assign bus.supervise   = pc_q[31];

`ifdef PC_FETCH_INSTR_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else if (!bus.stall) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.instr_cnt = cnt_q;
`endif

endmodule
